// File: rtl/key_expand_engine_pkg.sv
// Shared AES definitions for the key-expansion engine and the cipher datapath.
// Optional build macro: KEY_ZEROIZE_EN adds the ZERO state to the FSM encoding.
package aes_pkg;

  localparam logic [7:0] RCON_INIT = 8'h01;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    SUB  = 3'd2,
    CALC = 3'd3,
`ifdef KEY_ZEROIZE_EN
    DONE = 3'd4,
    ZERO = 3'd5
`else
    DONE = 3'd4
`endif
  } state_t;

  // Multiply by x in GF(2^8), reduction polynomial 0x11b.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Cyclic left rotation by one byte.
  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

endpackage

// File: rtl/key_expand_engine_if.sv
// Control / read bus between the key-expansion engine and its user.
interface key_expand_engine_if #(parameter int KEY_WORDS = 4);
  logic                   start;
  logic [32*KEY_WORDS-1:0] key_in;
  logic                   busy;
  logic                   done;
  logic                   key_valid;
  logic [3:0]             rd_round;
  logic [127:0]           rd_key;
  logic                   clear;

  modport master (output start, key_in, rd_round, clear,
                  input  busy, done, key_valid, rd_key);
  modport slave  (input  start, key_in, rd_round, clear,
                  output busy, done, key_valid, rd_key);
endinterface

// File: rtl/key_sub_word.sv
// Four parallel S-box lookups on a 32-bit word with a registered output.
module key_sub_word
  import aes_pkg::*;
(
  input  logic        clk,
  input  logic [31:0] word_in,
  output logic [31:0] word_out
);

  // Stage p1: registered substituted word
  always_ff @(posedge clk) begin
    word_out <= {SBOX[word_in[31:24]], SBOX[word_in[23:16]],
                 SBOX[word_in[15:8]],  SBOX[word_in[7:0]]};
  end

endmodule

// File: rtl/key_expand_engine.sv
// Iterative AES key expansion (128/192/256-bit keys), one schedule word per
// cycle into an internal round-key store readable by round index.
// Optional build macro: KEY_ZEROIZE_EN enables the clear / ZERO zeroise path.
module key_expand_engine
  import aes_pkg::*;
#(
  parameter int KEY_WORDS = 4
) (
  input  logic               clk,
  input  logic               reset,
  key_expand_engine_if.slave bus
);

  localparam int NR          = KEY_WORDS + 6;
  localparam int TOTAL_WORDS = 4 * (NR + 1);
  localparam int CW          = $clog2(TOTAL_WORDS + 1);

  state_t            state_q, state_d;
  logic [CW-1:0]     idx_q;
  logic [7:0]        rcon_q;
  logic              key_valid_q;
  logic [127:0]      rd_key_q;
  logic [31:0]       w [TOTAL_WORDS];
  logic [31:0]       prev_w, back_w, new_word, sub_in, sub_out;
  logic [CW-1:0]     base;

  // Word i starts a new key block (RotWord + SubWord + rcon).
  function automatic logic is_rot(input logic [CW-1:0] i);
    return (int'(i) % KEY_WORDS) == 0;
  endfunction

  // Word i needs a SubWord result from the S-box unit.
  function automatic logic needs_sub(input logic [CW-1:0] i);
    return is_rot(i) || (KEY_WORDS == 8 && (int'(i) % 8) == 4);
  endfunction

  key_sub_word u_sub (
    .clk      (clk),
    .word_in  (sub_in),
    .word_out (sub_out)
  );

`ifndef KEY_ZEROIZE_EN
  logic unused_clear;
  assign unused_clear = bus.clear;
`endif

  // Recurrence operands and the next schedule word
  always_comb begin
    prev_w   = w[idx_q - CW'(1)];
    back_w   = w[idx_q - CW'(KEY_WORDS)];
    sub_in   = is_rot(idx_q) ? rot_word(prev_w) : prev_w;
    new_word = back_w ^ prev_w;
    if (is_rot(idx_q))
      new_word = back_w ^ sub_out ^ {rcon_q, 24'h0};
    else if (needs_sub(idx_q))
      new_word = back_w ^ sub_out;
  end

  // Next-state logic and status outputs
  always_comb begin
    state_d  = state_q;
    bus.busy = 1'b0;
    bus.done = 1'b0;
    unique case (state_q)
      IDLE: begin
`ifdef KEY_ZEROIZE_EN
        if (bus.clear)      state_d = ZERO;
        else if (bus.start) state_d = LOAD;
`else
        if (bus.start)      state_d = LOAD;
`endif
      end
      LOAD: begin
        bus.busy = 1'b1;
        state_d  = needs_sub(CW'(KEY_WORDS)) ? SUB : CALC;
      end
      SUB: begin
        bus.busy = 1'b1;
        state_d  = CALC;
      end
      CALC: begin
        bus.busy = 1'b1;
        if (idx_q + CW'(1) == CW'(TOTAL_WORDS)) state_d = DONE;
        else if (needs_sub(idx_q + CW'(1)))     state_d = SUB;
        else                                    state_d = CALC;
      end
      DONE: begin
        bus.done = 1'b1;
        state_d  = IDLE;
      end
`ifdef KEY_ZEROIZE_EN
      ZERO: begin
        bus.busy = 1'b1;
        if (idx_q == CW'(TOTAL_WORDS - 1)) state_d = IDLE;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // Control registers: state, word counter, rcon, key_valid
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      rcon_q      <= RCON_INIT;
      key_valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        IDLE: begin
          if (state_d != IDLE) begin
            key_valid_q <= 1'b0;
            idx_q       <= '0;
          end
        end
        LOAD: begin
          idx_q  <= CW'(KEY_WORDS);
          rcon_q <= RCON_INIT;
        end
        CALC: begin
          idx_q <= idx_q + CW'(1);
          if (is_rot(idx_q)) rcon_q <= xtime(rcon_q);
          if (state_d == DONE) key_valid_q <= 1'b1;
        end
        DONE: rcon_q <= RCON_INIT;
`ifdef KEY_ZEROIZE_EN
        ZERO: idx_q <= idx_q + CW'(1);
`endif
        default: ;
      endcase
    end
  end

  // Round-key store writes; contents deliberately survive reset
  always_ff @(posedge clk) begin
    if (state_q == LOAD) begin
      for (int k = 0; k < KEY_WORDS; k++)
        w[k] <= bus.key_in[32*(KEY_WORDS-1-k) +: 32];
    end else if (state_q == CALC) begin
      w[idx_q] <= new_word;
    end
`ifdef KEY_ZEROIZE_EN
    else if (state_q == ZERO) begin
      w[idx_q] <= '0;
    end
`endif
  end

  assign base = CW'({bus.rd_round, 2'b00});

  // Registered round-key read port, out-of-range rounds read as zero
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      rd_key_q <= '0;
    else if (bus.rd_round > 4'(NR))
      rd_key_q <= '0;
    else
      rd_key_q <= {w[base], w[base + CW'(1)], w[base + CW'(2)], w[base + CW'(3)]};
  end

  assign bus.key_valid = key_valid_q;
  assign bus.rd_key    = rd_key_q;

endmodule

// File: tb/tb_key_expand_engine.sv
// Testbench for key_expand_engine: three instances (128/192/256-bit keys),
// a behavioural key-schedule model built from GF(2^8) arithmetic, a per-cycle
// compare process, and directed vectors with literal FIPS-197 round keys.
module tb_key_expand_engine;

  localparam int M_IDLE = 0, M_RUN = 1, M_DONE = 2, M_ZERO = 3;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  key_expand_engine_if #(.KEY_WORDS(4)) if4 ();
  key_expand_engine_if #(.KEY_WORDS(6)) if6 ();
  key_expand_engine_if #(.KEY_WORDS(8)) if8 ();

  key_expand_engine #(.KEY_WORDS(4)) dut4 (.clk(clk), .reset(reset), .bus(if4.slave));
  key_expand_engine #(.KEY_WORDS(6)) dut6 (.clk(clk), .reset(reset), .bus(if6.slave));
  key_expand_engine #(.KEY_WORDS(8)) dut8 (.clk(clk), .reset(reset), .bus(if8.slave));

  logic         start_v [3];
  logic         clear_v [3];
  logic [3:0]   rd_v    [3];
  logic [127:0] key4;
  logic [191:0] key6;
  logic [255:0] key8;

  assign if4.start = start_v[0]; assign if4.clear = clear_v[0];
  assign if4.rd_round = rd_v[0]; assign if4.key_in = key4;
  assign if6.start = start_v[1]; assign if6.clear = clear_v[1];
  assign if6.rd_round = rd_v[1]; assign if6.key_in = key6;
  assign if8.start = start_v[2]; assign if8.clear = clear_v[2];
  assign if8.rd_round = rd_v[2]; assign if8.key_in = key8;

  logic         busy_o [3];
  logic         done_o [3];
  logic         kv_o   [3];
  logic [127:0] rdk_o  [3];
  assign busy_o[0] = if4.busy; assign done_o[0] = if4.done;
  assign kv_o[0] = if4.key_valid; assign rdk_o[0] = if4.rd_key;
  assign busy_o[1] = if6.busy; assign done_o[1] = if6.done;
  assign kv_o[1] = if6.key_valid; assign rdk_o[1] = if6.rd_key;
  assign busy_o[2] = if8.busy; assign done_o[2] = if8.done;
  assign kv_o[2] = if8.key_valid; assign rdk_o[2] = if8.rd_key;

  // Model state
  logic [7:0]   sb [256];
  logic [31:0]  mw [3][60];
  int           nk_a [3] = '{4, 6, 8};
  int           tot  [3];
  int           nlat [3];
  int           mode [3] = '{0, 0, 0};
  int           cnt  [3] = '{0, 0, 0};
  logic         kv_m [3] = '{1'b0, 1'b0, 1'b0};
  logic         ok_m [3] = '{1'b0, 1'b0, 1'b0};
  logic         chk_m [3] = '{1'b0, 1'b0, 1'b0};
  logic [127:0] exp_rd [3];

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int n = 0; n < 8; n++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  // S-box from its definition: multiplicative inverse followed by the affine map
  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] subw(input logic [31:0] v);
    return {sb[v[31:24]], sb[v[23:16]], sb[v[15:8]], sb[v[7:0]]};
  endfunction

  // FIPS-197 key expansion; key is left-aligned in 256 bits
  task automatic model_expand(input int k, input logic [255:0] key);
    int nk;
    logic [7:0] rc;
    logic [31:0] t;
    nk = nk_a[k];
    rc = 8'h01;
    for (int i = 0; i < nk; i++) mw[k][i] = key[255 - 32*i -: 32];
    for (int i = nk; i < tot[k]; i++) begin
      t = mw[k][i-1];
      if (i % nk == 0) begin
        t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end else if (nk == 8 && i % 8 == 4) begin
        t = subw(t);
      end
      mw[k][i] = mw[k][i-nk] ^ t;
    end
  endtask

  function automatic logic [127:0] model_round(input int k, input int r);
    if (r > nk_a[k] + 6) return 128'h0;
    return {mw[k][4*r], mw[k][4*r+1], mw[k][4*r+2], mw[k][4*r+3]};
  endfunction

  // Behavioural model of handshake timing and store contents
  initial begin
    forever begin
      @(posedge clk or negedge reset);
      for (int k = 0; k < 3; k++) begin
        if (!reset) begin
          mode[k] = M_IDLE; kv_m[k] = 1'b0; ok_m[k] = 1'b0; chk_m[k] = 1'b0;
        end else begin
          chk_m[k]  = ok_m[k];
          exp_rd[k] = model_round(k, int'(rd_v[k]));
          case (mode[k])
            M_IDLE: begin
`ifdef KEY_ZEROIZE_EN
              if (clear_v[k]) begin
                mode[k] = M_ZERO; cnt[k] = 1; kv_m[k] = 1'b0; ok_m[k] = 1'b0;
              end else
`endif
              if (start_v[k]) begin
                mode[k] = M_RUN; cnt[k] = 1; kv_m[k] = 1'b0; ok_m[k] = 1'b0;
                if (k == 0) model_expand(k, {key4, 128'h0});
                else if (k == 1) model_expand(k, {key6, 64'h0});
                else model_expand(k, key8);
              end
            end
            M_RUN: begin
              cnt[k]++;
              if (cnt[k] == nlat[k]) begin
                mode[k] = M_DONE; kv_m[k] = 1'b1; ok_m[k] = 1'b1;
              end
            end
            M_DONE: mode[k] = M_IDLE;
            M_ZERO: begin
              cnt[k]++;
              if (cnt[k] == tot[k] + 1) begin
                mode[k] = M_IDLE; ok_m[k] = 1'b1;
                for (int i = 0; i < 60; i++) mw[k][i] = 32'h0;
              end
            end
            default: mode[k] = M_IDLE;
          endcase
        end
      end
    end
  end

  // Per-cycle compare of every instance against the model
  initial begin
    forever begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        check($sformatf("busy[%0d]", k), 128'(busy_o[k]),
              128'(mode[k] == M_RUN || mode[k] == M_ZERO));
        check($sformatf("done[%0d]", k), 128'(done_o[k]), 128'(mode[k] == M_DONE));
        check($sformatf("key_valid[%0d]", k), 128'(kv_o[k]), 128'(kv_m[k]));
        if (chk_m[k]) check($sformatf("rd_key[%0d]", k), rdk_o[k], exp_rd[k]);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse start, then watch done; optional extra start pulse at cycle extra_at
  task automatic run_expand(input int k, input int extra_at,
                            output int done_cyc, output int done_cnt, output logic kv_at_done);
    int c;
    start_v[k] = 1'b1;
    tick();
    start_v[k] = 1'b0;
    c = 1; done_cyc = -1; done_cnt = 0; kv_at_done = 1'b0;
    check($sformatf("kv_cleared_after_start[%0d]", k), 128'(kv_o[k]), 128'h0);
    while (c < 200) begin
      if (done_o[k]) begin
        if (done_cyc < 0) begin
          done_cyc = c;
          kv_at_done = kv_o[k];
        end
        done_cnt++;
      end
      start_v[k] = (c == extra_at);
      if (done_cyc > 0 && c > done_cyc + 20) break;
      tick();
      c++;
    end
    start_v[k] = 1'b0;
  endtask

  task automatic read_key(input int k, input int r, output logic [127:0] v);
    rd_v[k] = 4'(r);
    tick();
    v = rdk_o[k];
  endtask

  task automatic count_busy(input int k, output int bc, output int dc);
    bc = 0; dc = 0;
    while (busy_o[k] && bc < 200) begin
      if (done_o[k]) dc++;
      bc++;
      tick();
    end
  endtask

  int dcyc, dcnt, bc, dc;
  logic kvd;
  logic [127:0] v;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      start_v[k] = 1'b0; clear_v[k] = 1'b0; rd_v[k] = 4'd0;
      tot[k] = 4 * (nk_a[k] + 7);
      nlat[k] = 2 + tot[k] - nk_a[k];
      for (int i = nk_a[k]; i < tot[k]; i++)
        if (i % nk_a[k] == 0 || (nk_a[k] == 8 && i % 8 == 4)) nlat[k]++;
    end
    key4 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    key6 = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
    key8 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
    build_sbox();
    #23;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("reset_busy[%0d]", k), 128'(busy_o[k]), 128'h0);
      check($sformatf("reset_done[%0d]", k), 128'(done_o[k]), 128'h0);
      check($sformatf("reset_kv[%0d]", k), 128'(kv_o[k]), 128'h0);
      check($sformatf("reset_rd_key[%0d]", k), rdk_o[k], 128'h0);
    end
    reset = 1'b1;
    tick();

    // AES-128
    run_expand(0, -1, dcyc, dcnt, kvd);
    check("aes128_done_cycle", 128'(dcyc), 128'd52);
    check("aes128_done_count", 128'(dcnt), 128'd1);
    check("aes128_kv_at_done", 128'(kvd), 128'h1);
    check("model128_r1", model_round(0, 1), 128'ha0fafe1788542cb123a339392a6c7605);
    check("model128_r10", model_round(0, 10), 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    read_key(0, 0, v);  check("aes128_r0", v, 128'h2b7e151628aed2a6abf7158809cf4f3c);
    read_key(0, 1, v);  check("aes128_r1", v, 128'ha0fafe1788542cb123a339392a6c7605);
    read_key(0, 10, v); check("aes128_r10", v, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    read_key(0, 11, v); check("aes128_r11_oob", v, 128'h0);

    // AES-192
    run_expand(1, -1, dcyc, dcnt, kvd);
    check("aes192_done_cycle", 128'(dcyc), 128'd56);
    check("aes192_kv_at_done", 128'(kvd), 128'h1);
    check("model192_r12", model_round(1, 12), 128'he98ba06f448c773c8ecc720401002202);
    read_key(1, 12, v); check("aes192_r12", v, 128'he98ba06f448c773c8ecc720401002202);
    read_key(1, 13, v); check("aes192_r13_oob", v, 128'h0);

    // AES-256
    run_expand(2, -1, dcyc, dcnt, kvd);
    check("aes256_done_cycle", 128'(dcyc), 128'd67);
    check("aes256_kv_at_done", 128'(kvd), 128'h1);
    check("model256_r14", model_round(2, 14), 128'hfe4890d1e6188d0b046df344706c631e);
    read_key(2, 14, v); check("aes256_r14", v, 128'hfe4890d1e6188d0b046df344706c631e);
    read_key(2, 15, v); check("aes256_r15_oob", v, 128'h0);

    // Restart after done, with a second start while busy
    run_expand(0, 10, dcyc, dcnt, kvd);
    check("restart_done_cycle", 128'(dcyc), 128'd52);
    check("restart_done_count", 128'(dcnt), 128'd1);
    read_key(0, 10, v); check("restart_r10", v, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    // Reset pulsed in the middle of an expansion
    start_v[0] = 1'b1;
    tick();
    start_v[0] = 1'b0;
    repeat (19) tick();
    #1 reset = 1'b0;
    #1;
    check("midreset_busy", 128'(busy_o[0]), 128'h0);
    check("midreset_done", 128'(done_o[0]), 128'h0);
    check("midreset_kv", 128'(kv_o[0]), 128'h0);
    check("midreset_rd_key", rdk_o[0], 128'h0);
    #4 reset = 1'b1;
    tick();
    run_expand(0, -1, dcyc, dcnt, kvd);
    check("postreset_done_cycle", 128'(dcyc), 128'd52);
    read_key(0, 10, v); check("postreset_r10", v, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

`ifdef KEY_ZEROIZE_EN
    // Zeroise after an expansion
    clear_v[0] = 1'b1;
    tick();
    clear_v[0] = 1'b0;
    count_busy(0, bc, dc);
    check("zero_busy_cycles", 128'(bc), 128'd44);
    check("zero_kv", 128'(kv_o[0]), 128'h0);
    for (int r = 0; r <= 10; r++) begin
      read_key(0, r, v);
      check($sformatf("zero_r%0d", r), v, 128'h0);
    end

    // Clear and start together: only the zeroise happens
    run_expand(0, -1, dcyc, dcnt, kvd);
    check("rezero_expand_cycle", 128'(dcyc), 128'd52);
    clear_v[0] = 1'b1;
    start_v[0] = 1'b1;
    tick();
    clear_v[0] = 1'b0;
    start_v[0] = 1'b0;
    count_busy(0, bc, dc);
    check("clear_start_busy_cycles", 128'(bc), 128'd44);
    check("clear_start_no_done", 128'(dc), 128'd0);
    check("clear_start_kv", 128'(kv_o[0]), 128'h0);
    read_key(0, 10, v); check("clear_start_r10", v, 128'h0);
`endif

    repeat (3) tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/key_expand_engine.md
Name: key_expand_engine

Overview:
Parametrised iterative AES key-expansion engine. Successor to the single-round 128-bit key step; accepts 128/192/256-bit cipher keys.
On one start handshake it expands the full schedule into an internal round-key store, computing one word per cycle.
The cipher datapath reads any round key by index, so no per-round handshake with the key logic is needed.

Parameters:
KEY_WORDS, 4, key length in 32-bit words (legal: 4, 6, 8); NK below.
NR, KEY_WORDS+6, round count (derived localparam, not overridable).
TOTAL_WORDS, 4*(NR+1), schedule length in words (44/52/60; derived localparam).

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-low reset (asserted when 0)
start  in  1  one-cycle request to expand key_in; sampled only in IDLE
key_in  in  32*KEY_WORDS  cipher key, word 0 in the MSBs (FIPS-197 byte order)
busy  out  1  high while expansion is in progress
done  out  1  one-cycle pulse when the schedule is complete
key_valid  out  1  level; high from done until the next accepted start or reset
rd_round  in  4  round-key index to read (0..NR)
rd_key  out  128  round key rd_round (words 4r..4r+3); registered, 1-cycle latency
clear  in  1  zeroise request (only with KEY_ZEROIZE_EN; tie 0 otherwise)

Behaviour:
- Reset (async, reset=0): state IDLE; busy=0, done=0, key_valid=0, rd_key=0; rcon=8'h01; word counter=0. The store is not cleared by reset.
- State IDLE:
  - start=1 -> LOAD.
  - key_valid drops in the cycle after start is sampled.
- State LOAD (1 cycle): write key_in into words 0..NK-1; i=NK; busy=1 -> CALC, or SUB if i needs SubWord.
- Word i needs SubWord when i mod NK==0, or when NK==8 and i mod 8==4.
- State SUB (1 cycle): present temp=w[i-1] to the sub_word unit. The unit registers its result, which is consumed in CALC.
- State CALC (1 cycle): write w[i] and increment i.
  - i mod NK==0: w[i] = w[i-NK] ^ SubWord(RotWord(w[i-1])) ^ {rcon,24'h0}; then rcon=xtime(rcon) (0x80->0x1b->0x36).
  - NK==8 and i mod 8==4: w[i] = w[i-NK] ^ SubWord(w[i-1]).
  - Otherwise: w[i] = w[i-NK] ^ w[i-1].
  - Next state: SUB if the new i needs SubWord; DONE if i==TOTAL_WORDS; else CALC.
- State DONE (1 cycle): done=1, key_valid=1, busy=0; rcon restored to 0x01 -> IDLE.
- Latency: done is high exactly N cycles after the clock edge that samples start.
  - NK=4: N=52.
  - NK=6: N=56.
  - NK=8: N=67.
  - Formula: N = 1 LOAD + (TOTAL_WORDS-NK) CALC + SubWord-count SUB + 1.
- start while busy or in DONE is ignored; no queuing.
- rd_key is updated every cycle from rd_round, busy or not. While busy, content is undefined and key_valid=0. rd_round>NR returns 128'h0.
- Reset mid-expansion: return to IDLE immediately, key_valid=0; the partial store is left as is.
- All arithmetic is GF(2^8) XOR; no carries. rcon is 8 bits with xtime reduction polynomial 0x11b.

Optional Feature:
KEY_ZEROIZE_EN
- Defined: in IDLE, clear=1 enters ZERO state, which writes 0 to one word per cycle for TOTAL_WORDS cycles with busy=1.
  - Then IDLE with key_valid=0, and rd_key reads 0 for every index.
  - clear and start in the same IDLE cycle: clear wins.
  - clear while busy: ignored.
- Undefined: clear is unused, the ZERO state does not exist, and the store is only overwritten by a new expansion.

Decomposition:
- Package aes_pkg: S-box constant table, xtime function, RotWord function, the state enum (IDLE, LOAD, SUB, CALC, DONE, ZERO), and RCON_INIT=8'h01.
- Sub-module key_sub_word: 4 parallel S-box lookups on a 32-bit word, output registered. It is reused by the cipher datapath.

Test Plan:
- AES-128 key 2b7e151628aed2a6abf7158809cf4f3c, start:
  - done at cycle 52, key_valid=1.
  - rd_round=1 -> a0fafe1788542cb123a339392a6c7605.
  - rd_round=10 -> d014f9a8c9ee2589e13f0cc8b6630ca6.
- AES-192 (KEY_WORDS=6), key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b:
  - done at cycle 56.
  - rd_round=12 -> e98ba06f448c773c8ecc720401002202.
- AES-256 (KEY_WORDS=8), key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4:
  - done at cycle 67.
  - rd_round=14 -> fe4890d1e6188d0b046df344706c631e.
- Busy and restart handling (AES-128):
  - Second start at cycle 10 is ignored; results are identical and done occurs once.
  - A new start after done clears key_valid the next cycle.
- reset pulsed low at cycle 20 of an expansion:
  - Outputs go to 0 asynchronously.
  - A new start then reproduces the round-10 vector at cycle 52.
- KEY_ZEROIZE_EN defined, clear after an AES-128 expansion:
  - busy for 44 cycles, then rd_round 0..10 all read 0 and key_valid=0.
  - Simultaneous clear+start performs the zeroise only.
